// File: rtl/ps2_key_event_gen.sv
// PS/2 keyboard receiver producing toggle-flagged 11-bit ps2_key events.
// Deglitches the PS/2 clock, frames bytes and folds the E0/F0/E1 prefixes into key events.
module ps2_key_event_gen #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 96000
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FiltMax = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic [1:0]    clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  state_e        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          par_err_q, par_err_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          byte_valid_q, byte_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          ext_q, ext_d, rel_q, rel_d;
  logic [2:0]    skip_q, skip_d;
  logic [10:0]   key_q, key_d;

  logic clk_s, data_s, strobe, timeout, err_clr;

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];

  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk_in};
    data_sync_d = {data_sync_q[0], ps2_data_in};

    // Any return to the accepted level restarts the count, so short glitches never land.
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s != filt_q) begin
      if (fcnt_q == FiltMax) begin
        filt_d = clk_s;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
    strobe = filt_q & ~filt_d;
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    par_err_d    = par_err_q;
    tmo_d        = tmo_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    err_clr      = 1'b0;
    timeout      = 1'b0;

    if (state_q == StIdle || strobe) begin
      tmo_d = '0;
    end else if (tmo_q == TmoLast) begin
      timeout = 1'b1;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (strobe) begin
          if (!data_s) begin
            state_d   = StData;
            bit_cnt_d = '0;
            par_err_d = 1'b0;
          end else begin
            frame_err_d = 1'b1;
            err_clr     = 1'b1;
          end
        end
      end
      StData: begin
        if (strobe) begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
      end
      StParity: begin
        if (strobe) begin
          par_err_d = ~(^shift_q ^ data_s);
          state_d   = StStop;
        end
      end
      StStop: begin
        if (strobe) begin
          if (data_s && !par_err_q) begin
            byte_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            err_clr     = 1'b1;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Timeout only fires without a strobe, so it never collides with the case above.
    if (timeout) begin
      state_d     = StIdle;
      tmo_d       = '0;
      frame_err_d = 1'b1;
    end
  end

  always_comb begin
    ext_d  = ext_q;
    rel_d  = rel_q;
    skip_d = skip_q;
    key_d  = key_q;
    if (err_clr) begin
      ext_d  = 1'b0;
      rel_d  = 1'b0;
      skip_d = '0;
    end else if (byte_valid_q) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
      end else begin
        case (shift_q)
          8'hE1: begin
            skip_d = 3'd7;
            ext_d  = 1'b0;
            rel_d  = 1'b0;
          end
          8'hE0: ext_d = 1'b1;
          8'hF0: rel_d = 1'b1;
          8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: begin
            ext_d = 1'b0;
            rel_d = 1'b0;
          end
          default: begin
            key_d = {~key_q[10], ~rel_q, ext_q, shift_q};
            ext_d = 1'b0;
            rel_d = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      clk_sync_q   <= 2'b11;
      data_sync_q  <= 2'b11;
      filt_q       <= 1'b1;
      fcnt_q       <= '0;
      state_q      <= StIdle;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      par_err_q    <= 1'b0;
      tmo_q        <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      ext_q        <= 1'b0;
      rel_q        <= 1'b0;
      skip_q       <= '0;
      key_q        <= '0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      data_sync_q  <= data_sync_d;
      filt_q       <= filt_d;
      fcnt_q       <= fcnt_d;
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      par_err_q    <= par_err_d;
      tmo_q        <= tmo_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      ext_q        <= ext_d;
      rel_q        <= rel_d;
      skip_q       <= skip_d;
      key_q        <= key_d;
    end
  end

  assign ps2_key   = key_q;
  assign frame_err = frame_err_q;

endmodule
